testro_mem_readout: RTL
=======================

// Module: testro_mem_readout
// PURPOSE
//  Avalon-MM read master for the 128-bit TestRO on-chip sample memory (s1 port, 18750 words).
//  - On start: reads word_count consecutive words from start_addr.
//  - Serializes each word LSB-byte-first onto a valid/ready byte stream feeding the comm link TX.
//  - Sits between the sample RAM and the link framer.
// PARAMETERS
//  ADDR_W   15     memory word-address width
//  DATA_W   128    memory data width; must be an integer multiple of OUT_W
//  OUT_W    8      output stream beat width
//  DEPTH    18750  number of valid memory words; highest legal address is DEPTH-1
// PORTS
//  clk             in   1       system clock
//  reset_n         in   1       asynchronous active-low reset
//  start           in   1       1-cycle request; sampled only in IDLE
//  start_addr      in   ADDR_W  first word address
//  word_count      in   ADDR_W  number of words to read; 0 = no-op
//  busy            out  1       high from accepted start until done
//  done            out  1       1-cycle pulse after the last beat is accepted
//  err_range       out  1       1-cycle pulse: start rejected, start_addr+word_count > DEPTH
//  mem_address     out  ADDR_W  Avalon address
//  mem_chipselect  out  1       Avalon chipselect; high only in the read-issue cycle
//  mem_write       out  1       tied 0
//  mem_byteenable  out  DATA_W/8  tied all-ones
//  mem_clken       out  1       tied 1
//  mem_readdata    in   DATA_W  Avalon readdata; valid one cycle after address
//  out_data        out  OUT_W   stream data
//  out_valid       out  1       stream valid
//  out_ready       in   1       stream ready from sink
//  out_last        out  1       high on the final beat of the final word
// BEHAVIOUR
//  Reset values: all outputs 0, except mem_clken=1 and mem_byteenable=all-ones. FSM enters IDLE.
//  Reset mid-transfer: the transfer is abandoned, no done pulse is issued, and outputs return to reset values.
//  Start check: the range check uses ADDR_W+1-bit arithmetic on start_addr+word_count.
//    - Sum > DEPTH: err_range pulses the next cycle, busy stays 0, no memory access.
//    - word_count==0: done pulses the next cycle, busy stays 0, no memory access.
//  FSM states: IDLE -> ISSUE -> CAPT -> SHIFT -> (ISSUE | FIN) -> IDLE.
//  IDLE: on a legal start, latch addr/count, go to ISSUE, set busy=1.
//  ISSUE: drive mem_address=addr and mem_chipselect=1 for exactly one cycle; go to CAPT.
//  CAPT: register mem_readdata into the shift register; addr++, count--; go to SHIFT.
//  SHIFT:
//    - out_data = shreg[OUT_W-1:0] and out_valid=1.
//    - Each beat is accepted on (out_valid & out_ready); on acceptance, shift right by OUT_W and advance the beat counter.
//    - out_data is held stable while out_valid=1 and out_ready=0.
//    - After beat DATA_W/OUT_W-1 is accepted: go to ISSUE if count!=0, else to FIN.
//  FIN: busy drops; done pulses for one cycle; return to IDLE.
//  Stream protocol:
//    - out_valid never drops without acceptance.
//    - out_last asserts only together with out_valid on the final beat.
//  Throughput without prefetch: 16 beats plus a 2-cycle gap (ISSUE, CAPT) per word.
//  Other rules:
//    - start is ignored while busy=1.
//    - Addresses never wrap; the start check guarantees the last address is <= DEPTH-1.
// CONFIGURATION
//  MEM_PREFETCH_EN defined:
//    - Adds a second DATA_W holding register.
//    - The next word's ISSUE/CAPT overlaps the current word's SHIFT; the prefetched word loads the shift register in the same cycle the last beat is accepted.
//    - Result: zero idle cycles between words under continuous out_ready.
//    - Reads are never issued beyond word_count.
//  MEM_PREFETCH_EN undefined: single shift register; 2-cycle inter-word gap as described under BEHAVIOUR.
//  Stream content and ordering are identical in both builds.
// TESTING
//  1. start_addr=0, word_count=1, mem[0]=128'h0F0E..0100, out_ready=1
//     -> bytes 00,01,..,0F; out_last on 0F; done 1 cycle later.
//  2. start_addr=100, word_count=3, out_ready toggled randomly
//     -> 48 beats in order; data stable during stalls; exactly 3 chipselect pulses at addresses 100, 101, 102.
//  3. start_addr=18749, word_count=2
//     -> err_range pulse; busy=0; no chipselect.
//  4. start_addr=18748, word_count=2 (boundary legal)
//     -> 32 beats from addresses 18748 and 18749; done.
//  5. word_count=0 -> done pulse, no beats. Second start while busy -> ignored, no change to the stream.
//  6. reset_n low at beat 5 of word 2
//     -> outputs return to reset values immediately, no done; a new start afterwards runs cleanly.
//     With MEM_PREFETCH_EN, word_count=4 and out_ready=1 -> 64 consecutive valid beats with no gap.

Source files
------------

// File: rtl/testro_mem_readout.sv
// testro_mem_readout: Avalon-MM read master that streams sample-RAM words LSB-byte-first onto a valid/ready byte link.
// Define MEM_PREFETCH_EN to overlap the next word's read with the current word's serialization.
module testro_mem_readout #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 128,
    parameter int OUT_W  = 8,
    parameter int DEPTH  = 18750
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     start_addr_i,
    input  logic [ADDR_W-1:0]     word_count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_range_o,
    output logic [ADDR_W-1:0]     mem_address_o,
    output logic                  mem_chipselect_o,
    output logic                  mem_write_o,
    output logic [DATA_W/8-1:0]   mem_byteenable_o,
    output logic                  mem_clken_o,
    input  logic [DATA_W-1:0]     mem_readdata_i,
    output logic [OUT_W-1:0]      out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o
);
    localparam int BEATS = DATA_W / OUT_W;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    typedef enum logic [2:0] {IDLE, ISSUE, CAPT, SHIFT, FIN} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BW-1:0] beat_q, beat_d;
    logic done_q, done_d, err_q, err_d;
    logic [ADDR_W:0] sum;
    logic last_beat, more, step;
`ifdef MEM_PREFETCH_EN
    logic [DATA_W-1:0] hold_q, hold_d;
    logic hold_v_q, hold_v_d, pend_q, pf_issue;
    // A background read is allowed only when its data has a guaranteed free slot.
    assign pf_issue = state_q == SHIFT && cnt_q != '0 && !pend_q && !hold_v_q;
    assign mem_chipselect_o = state_q == ISSUE || pf_issue;
    assign step = mem_chipselect_o;
    assign more = cnt_q != '0 || pend_q || hold_v_q;
`else
    assign mem_chipselect_o = state_q == ISSUE;
    assign step = state_q == CAPT;
    assign more = cnt_q != '0;
`endif
    assign sum = {1'b0, start_addr_i} + {1'b0, word_count_i};
    assign last_beat = beat_q == BW'(BEATS - 1);
    assign busy_o = state_q == ISSUE || state_q == CAPT || state_q == SHIFT;
    assign done_o = done_q || state_q == FIN;
    assign err_range_o = err_q;
    assign mem_address_o = mem_chipselect_o ? addr_q : '0;
    assign mem_write_o = 1'b0;
    assign mem_byteenable_o = '1;
    assign mem_clken_o = 1'b1;
    assign out_valid_o = state_q == SHIFT;
    assign out_data_o = out_valid_o ? sh_q[OUT_W-1:0] : '0;
    assign out_last_o = out_valid_o && last_beat && !more;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_PREFETCH_EN
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            pend_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MEM_PREFETCH_EN
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            pend_q   <= pf_issue;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = step ? addr_q + ADDR_W'(1) : addr_q;
        cnt_d   = step ? cnt_q - ADDR_W'(1) : cnt_q;
        sh_d    = sh_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef MEM_PREFETCH_EN
        hold_d   = (pend_q && state_q == SHIFT) ? mem_readdata_i : hold_q;
        hold_v_d = (pend_q && state_q == SHIFT) || hold_v_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                err_d  = sum > (ADDR_W + 1)'(DEPTH);
                done_d = !err_d && word_count_i == '0;
                if (!err_d && !done_d) begin
                    state_d = ISSUE;
                    addr_d  = start_addr_i;
                    cnt_d   = word_count_i;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                sh_d    = mem_readdata_i;
                beat_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: if (out_ready_i) begin
                sh_d   = sh_q >> OUT_W;
                beat_d = last_beat ? '0 : beat_q + BW'(1);
`ifdef MEM_PREFETCH_EN
                // A word landing this very cycle bypasses the holding register.
                if (last_beat) begin
                    sh_d     = pend_q ? mem_readdata_i : hold_q;
                    hold_v_d = 1'b0;
                    state_d  = (pend_q || hold_v_q) ? SHIFT : (more ? CAPT : FIN);
                end
`else
                if (last_beat) state_d = more ? ISSUE : FIN;
`endif
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
